// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: types and constants shared by the 2:1 memory arbiter files.
//
// The opaque field in the payload structs is sized to MEM_ARB_OPAQ_MAX bits.
// The arbiter uses only the low p_opaq_bits+1 bits (client tag plus source
// bit) and keeps the rest zero, so p_opaq_bits must not exceed
// MEM_ARB_OPAQ_MAX-1.
package mem_arb_pkg;

    localparam logic MEM_OP_READ  = 1'b0;
    localparam logic MEM_OP_WRITE = 1'b1;

    localparam int MEM_ARB_OPAQ_MAX = 16;

    typedef enum logic {
        ARB_SRC_INST = 1'b0,
        ARB_SRC_DATA = 1'b1
    } arb_src_t;

    typedef struct packed {
        logic                        op;
        logic [MEM_ARB_OPAQ_MAX-1:0] opaque;
        logic [31:0]                 addr;
        logic [31:0]                 data;
        logic [3:0]                  strb;
    } mem_req_t;

    typedef struct packed {
        logic                        op;
        logic [MEM_ARB_OPAQ_MAX-1:0] opaque;
        logic [31:0]                 data;
    } mem_resp_t;

endpackage

// File: rtl/mem_arbiter_2to1_if.sv
// mem_arbiter_2to1_if: one memory port (request + response channels).
//
// master: issues requests, consumes responses (processor side / arbiter m port)
// slave : accepts requests, produces responses (arbiter client ports / memory)
//
// req_*  : val/rdy handshake, op, opaque tag, addr, write data, byte strobes
// resp_* : val/rdy handshake, echoed op, echoed opaque tag, read data
interface mem_arbiter_2to1_if #(
    parameter int p_opaq_bits = 8
);
    logic                   req_val;
    logic                   req_rdy;
    logic                   req_op;
    logic [p_opaq_bits-1:0] req_opaque;
    logic [31:0]            req_addr;
    logic [31:0]            req_data;
    logic [3:0]             req_strb;

    logic                   resp_val;
    logic                   resp_rdy;
    logic                   resp_op;
    logic [p_opaq_bits-1:0] resp_opaque;
    logic [31:0]            resp_data;

    modport master (
        output req_val, req_op, req_opaque, req_addr, req_data, req_strb,
        input  req_rdy,
        input  resp_val, resp_op, resp_opaque, resp_data,
        output resp_rdy
    );

    modport slave (
        input  req_val, req_op, req_opaque, req_addr, req_data, req_strb,
        output req_rdy,
        output resp_val, resp_op, resp_opaque, resp_data,
        input  resp_rdy
    );
endinterface

// File: rtl/mem_arbiter_2to1_pipe_reg.sv
// pipe_reg_1entry: single-entry registered val/rdy pipeline stage.
//
// clk, rst          : clock, asynchronous active-low reset
// in_val/in_rdy     : upstream handshake, in_data payload
// out_val/out_rdy   : downstream handshake, out_data payload (registered)
//
// Accepts a new entry when empty or when the current entry drains in the same
// cycle, which gives one transfer per cycle with a one-cycle latency.
module pipe_reg_1entry #(
    parameter type T = logic [7:0]
) (
    input  logic clk,
    input  logic rst,
    input  logic in_val,
    output logic in_rdy,
    input  T     in_data,
    output logic out_val,
    input  logic out_rdy,
    output T     out_data
);

    assign in_rdy = !out_val || out_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_val  <= 1'b0;
            out_data <= '0;
        end else if (in_rdy) begin
            out_val <= in_val;
            if (in_val) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_2to1.sv
// mem_arbiter_2to1: merges the inst (c0) and data (c1) client ports onto one
// memory server port with round-robin arbitration.
//
// clk, rst : clock, asynchronous active-low reset
// c0, c1   : client ports (slave modport, opaque width p_opaq_bits)
// m        : server port (master modport, opaque width p_opaq_bits+1)
// stat_*   : present only when MEM_ARB_STATS_EN is defined; grant counts per
//            client and count of cycles with both clients eligible
//
// The source id is carried in the MSB of the server-side opaque field and used
// to route responses, so responses may come back in any order. Each client
// may have at most p_max_outstanding (1..15) requests in flight.
module mem_arbiter_2to1
    import mem_arb_pkg::*;
#(
    parameter int p_opaq_bits       = 8,
    parameter int p_max_outstanding = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_arbiter_2to1_if.slave   c0,
    mem_arbiter_2to1_if.slave   c1,
    mem_arbiter_2to1_if.master  m
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]         stat_grant0,
    output logic [31:0]         stat_grant1,
    output logic [31:0]         stat_conflict
`endif
);

    localparam int CW = $clog2(p_max_outstanding + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(p_max_outstanding);

    logic [CW-1:0] out_cnt [2];
    arb_src_t      prio;
    logic [1:0]    elig, gnt, req_hs, resp_hs;

    mem_req_t  req_in, req_q;
    logic      req_in_rdy, req_q_val;
    mem_resp_t resp_in, resp_q;
    logic      resp_in_rdy, resp_q_val, resp_out_rdy, resp_src;
    logic      unused_opaq;

    assign elig[0] = c0.req_val && (out_cnt[0] < CNT_MAX);
    assign elig[1] = c1.req_val && (out_cnt[1] < CNT_MAX);

    // prio only matters when both clients are eligible
    assign gnt[0] = elig[0] && (!elig[1] || prio == ARB_SRC_INST);
    assign gnt[1] = elig[1] && !gnt[0];

    assign c0.req_rdy = req_in_rdy && gnt[0];
    assign c1.req_rdy = req_in_rdy && gnt[1];
    assign req_hs     = {c1.req_val && c1.req_rdy, c0.req_val && c0.req_rdy};

    always_comb begin
        req_in = '0;
        if (gnt[1]) begin
            req_in.op                   = c1.req_op;
            req_in.opaque[p_opaq_bits:0] = {1'(ARB_SRC_DATA), c1.req_opaque};
            req_in.addr                 = c1.req_addr;
            req_in.data                 = c1.req_data;
            req_in.strb                 = c1.req_strb;
        end else begin
            req_in.op                   = c0.req_op;
            req_in.opaque[p_opaq_bits:0] = {1'(ARB_SRC_INST), c0.req_opaque};
            req_in.addr                 = c0.req_addr;
            req_in.data                 = c0.req_data;
            req_in.strb                 = c0.req_strb;
        end
    end

    pipe_reg_1entry #(.T(mem_req_t)) u_req_reg (
        .clk      (clk),
        .rst      (rst),
        .in_val   (gnt[0] || gnt[1]),
        .in_rdy   (req_in_rdy),
        .in_data  (req_in),
        .out_val  (req_q_val),
        .out_rdy  (m.req_rdy),
        .out_data (req_q)
    );

    assign m.req_val    = req_q_val;
    assign m.req_op     = req_q.op;
    assign m.req_opaque = req_q.opaque[p_opaq_bits:0];
    assign m.req_addr   = req_q.addr;
    assign m.req_data   = req_q.data;
    assign m.req_strb   = req_q.strb;

    always_comb begin
        resp_in                       = '0;
        resp_in.op                    = m.resp_op;
        resp_in.opaque[p_opaq_bits:0] = m.resp_opaque;
        resp_in.data                  = m.resp_data;
    end

    pipe_reg_1entry #(.T(mem_resp_t)) u_resp_reg (
        .clk      (clk),
        .rst      (rst),
        .in_val   (m.resp_val),
        .in_rdy   (resp_in_rdy),
        .in_data  (resp_in),
        .out_val  (resp_q_val),
        .out_rdy  (resp_out_rdy),
        .out_data (resp_q)
    );

    assign m.resp_rdy = resp_in_rdy;

    // A stalled client holds the single response entry, blocking both clients.
    assign resp_src     = resp_q.opaque[p_opaq_bits];
    assign resp_out_rdy = resp_src ? c1.resp_rdy : c0.resp_rdy;

    assign c0.resp_val    = resp_q_val && (resp_src == ARB_SRC_INST);
    assign c1.resp_val    = resp_q_val && (resp_src == ARB_SRC_DATA);
    assign c0.resp_op     = resp_q.op;
    assign c1.resp_op     = resp_q.op;
    assign c0.resp_opaque = resp_q.opaque[p_opaq_bits-1:0];
    assign c1.resp_opaque = resp_q.opaque[p_opaq_bits-1:0];
    assign c0.resp_data   = (resp_q.op == MEM_OP_WRITE) ? 32'h0 : resp_q.data;
    assign c1.resp_data   = (resp_q.op == MEM_OP_WRITE) ? 32'h0 : resp_q.data;

    assign resp_hs = {c1.resp_val && c1.resp_rdy, c0.resp_val && c0.resp_rdy};

    // Opaque bits above the server width are always zero and never read.
    assign unused_opaq = ^{req_q.opaque, resp_q.opaque};

    // Priority flips to the other client after every accepted request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio <= ARB_SRC_INST;
        end else if (req_hs[0]) begin
            prio <= ARB_SRC_DATA;
        end else if (req_hs[1]) begin
            prio <= ARB_SRC_INST;
        end
    end

    // Simultaneous issue and return leave the count unchanged; saturation at
    // CNT_MAX is unreachable because eligibility already blocks the grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_cnt[0] <= '0;
            out_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                case ({req_hs[i], resp_hs[i]})
                    2'b10: if (out_cnt[i] != CNT_MAX) out_cnt[i] <= out_cnt[i] + CW'(1);
                    2'b01: if (out_cnt[i] != '0)      out_cnt[i] <= out_cnt[i] - CW'(1);
                    default: ;
                endcase
            end
        end
    end

`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_grant0   <= '0;
            stat_grant1   <= '0;
            stat_conflict <= '0;
        end else begin
            if (req_hs[0])         stat_grant0   <= stat_grant0 + 32'd1;
            if (req_hs[1])         stat_grant1   <= stat_grant1 + 32'd1;
            if (elig[0] && elig[1]) stat_conflict <= stat_conflict + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter_2to1.sv
// tb_mem_arbiter_2to1: directed self-checking bench for mem_arbiter_2to1.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge. Builds with or without MEM_ARB_STATS_EN.
module tb_mem_arbiter_2to1;

    logic clk;
    logic rst;
    int   check_cnt;
    int   pass_cnt;

    mem_arbiter_2to1_if #(.p_opaq_bits(8)) c0_if ();
    mem_arbiter_2to1_if #(.p_opaq_bits(8)) c1_if ();
    mem_arbiter_2to1_if #(.p_opaq_bits(9)) m_if ();

`ifdef MEM_ARB_STATS_EN
    logic [31:0] stat_grant0, stat_grant1, stat_conflict;
`endif

    mem_arbiter_2to1 #(.p_opaq_bits(8), .p_max_outstanding(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .c0            (c0_if),
        .c1            (c1_if),
        .m             (m_if)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_grant0   (stat_grant0),
        .stat_grant1   (stat_grant1),
        .stat_conflict (stat_conflict)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] actual,
                                input logic [63:0] expected);
        check_cnt++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        else
            pass_cnt++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input int client, input logic val, input logic op,
                                  input logic [7:0] opq, input logic [31:0] addr,
                                  input logic [31:0] data, input logic [3:0] strb);
        if (client == 0) begin
            c0_if.req_val = val; c0_if.req_op = op; c0_if.req_opaque = opq;
            c0_if.req_addr = addr; c0_if.req_data = data; c0_if.req_strb = strb;
        end else begin
            c1_if.req_val = val; c1_if.req_op = op; c1_if.req_opaque = opq;
            c1_if.req_addr = addr; c1_if.req_data = data; c1_if.req_strb = strb;
        end
    endtask

    task automatic apply_server_resp(input logic val, input logic op,
                                     input logic [8:0] opq, input logic [31:0] data);
        m_if.resp_val = val; m_if.resp_op = op; m_if.resp_opaque = opq; m_if.resp_data = data;
    endtask

    // Echo whatever the server port shows as a response, data = address.
    task automatic echo_server();
        if (m_if.req_val)
            apply_server_resp(1'b1, m_if.req_op, m_if.req_opaque, m_if.req_addr);
        else
            apply_server_resp(1'b0, 1'b0, 9'h0, 32'h0);
    endtask

    initial begin
        check_cnt = 0;
        pass_cnt  = 0;
        rst = 1'b0;
        apply_stimulus(0, 1'b0, 1'b0, 8'h0, 32'h0, 32'h0, 4'h0);
        apply_stimulus(1, 1'b0, 1'b0, 8'h0, 32'h0, 32'h0, 4'h0);
        apply_server_resp(1'b0, 1'b0, 9'h0, 32'h0);
        c0_if.resp_rdy = 1'b1;
        c1_if.resp_rdy = 1'b1;
        m_if.req_rdy   = 1'b1;

        // Reset state
        @(negedge clk);
        check_output("rst_m_req_val", m_if.req_val, 1'b0);
        check_output("rst_c0_resp_val", c0_if.resp_val, 1'b0);
        check_output("rst_c1_resp_val", c1_if.resp_val, 1'b0);
        check_output("rst_m_req_opaque", m_if.req_opaque, 9'h0);
        check_output("rst_m_resp_rdy", m_if.resp_rdy, 1'b1);
`ifdef MEM_ARB_STATS_EN
        check_output("rst_stat_grant0", stat_grant0, 32'd0);
        check_output("rst_stat_conflict", stat_conflict, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        step();

        // Single read from c0
        apply_stimulus(0, 1'b1, 1'b0, 8'h05, 32'h100, 32'h0, 4'hF);
        @(negedge clk);
        check_output("t1_c0_req_rdy", c0_if.req_rdy, 1'b1);
        check_output("t1_m_req_val_early", m_if.req_val, 1'b0);
        step();
        apply_stimulus(0, 1'b0, 1'b0, 8'h0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        check_output("t1_m_req_val", m_if.req_val, 1'b1);
        check_output("t1_m_req_opaque", m_if.req_opaque, 9'h005);
        check_output("t1_m_req_addr", m_if.req_addr, 32'h100);
        step();
        apply_server_resp(1'b1, 1'b0, 9'h005, 32'hDEADBEEF);
        @(negedge clk);
        check_output("t1_m_req_drained", m_if.req_val, 1'b0);
        step();
        apply_server_resp(1'b0, 1'b0, 9'h0, 32'h0);
        @(negedge clk);
        check_output("t1_c0_resp_val", c0_if.resp_val, 1'b1);
        check_output("t1_c0_resp_data", c0_if.resp_data, 32'hDEADBEEF);
        check_output("t1_c0_resp_opaque", c0_if.resp_opaque, 8'h05);
        check_output("t1_c1_resp_val", c1_if.resp_val, 1'b0);
        step();
        @(negedge clk);
        check_output("t1_c0_resp_done", c0_if.resp_val, 1'b0);
        step();

        // Both clients every cycle: priority now points at c1 after c0's grant
        apply_stimulus(0, 1'b1, 1'b0, 8'h0A, 32'h110, 32'h0, 4'hF);
        apply_stimulus(1, 1'b1, 1'b0, 8'h0B, 32'h210, 32'h0, 4'hF);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_output($sformatf("t2_c0_rdy_%0d", k), c0_if.req_rdy, (k % 2) == 1);
            check_output($sformatf("t2_c1_rdy_%0d", k), c1_if.req_rdy, (k % 2) == 0);
            if (k > 0)
                check_output($sformatf("t2_m_opq_%0d", k), m_if.req_opaque,
                             ((k - 1) % 2 == 0) ? 9'h10B : 9'h00A);
            step();
        end
        apply_stimulus(0, 1'b0, 1'b0, 8'h0, 32'h0, 32'h0, 4'h0);
        apply_stimulus(1, 1'b0, 1'b0, 8'h0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        check_output("t2_m_opq_3", m_if.req_opaque, 9'h00A);
        step();
        for (int k = 0; k < 4; k++) begin
            apply_server_resp(1'b1, 1'b0, (k % 2 == 0) ? 9'h10B : 9'h00A, 32'h1000 + k);
            step();
            @(negedge clk);
            if (k % 2 == 0) begin
                check_output($sformatf("t2_c1_rval_%0d", k), c1_if.resp_val, 1'b1);
                check_output($sformatf("t2_c0_rval_%0d", k), c0_if.resp_val, 1'b0);
                check_output($sformatf("t2_c1_ropq_%0d", k), c1_if.resp_opaque, 8'h0B);
                check_output($sformatf("t2_c1_rdata_%0d", k), c1_if.resp_data, 32'h1000 + k);
            end else begin
                check_output($sformatf("t2_c0_rval_%0d", k), c0_if.resp_val, 1'b1);
                check_output($sformatf("t2_c1_rval_%0d", k), c1_if.resp_val, 1'b0);
                check_output($sformatf("t2_c0_ropq_%0d", k), c0_if.resp_opaque, 8'h0A);
                check_output($sformatf("t2_c0_rdata_%0d", k), c0_if.resp_data, 32'h1000 + k);
            end
        end
        apply_server_resp(1'b0, 1'b0, 9'h0, 32'h0);
        step();

        // Outstanding limit on c1
        apply_stimulus(1, 1'b1, 1'b0, 8'h0E, 32'h220, 32'h0, 4'hF);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_output($sformatf("t3_c1_rdy_%0d", k), c1_if.req_rdy, 1'b1);
            step();
        end
        apply_stimulus(0, 1'b1, 1'b0, 8'h0C, 32'h104, 32'h0, 4'hF);
        @(negedge clk);
        check_output("t3_c1_rdy_sat", c1_if.req_rdy, 1'b0);
        check_output("t3_c0_rdy_sat", c0_if.req_rdy, 1'b1);
        step();
        apply_stimulus(0, 1'b0, 1'b0, 8'h0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        check_output("t3_c1_rdy_still", c1_if.req_rdy, 1'b0);
        apply_server_resp(1'b1, 1'b0, 9'h10E, 32'h2222);
        step();
        apply_server_resp(1'b0, 1'b0, 9'h0, 32'h0);
        @(negedge clk);
        check_output("t3_c1_resp_val", c1_if.resp_val, 1'b1);
        check_output("t3_c1_rdy_pre", c1_if.req_rdy, 1'b0);
        step();
        @(negedge clk);
        check_output("t3_c1_rdy_back", c1_if.req_rdy, 1'b1);
        apply_stimulus(1, 1'b0, 1'b0, 8'h0, 32'h0, 32'h0, 4'h0);
        step();

        // Out-of-order return: c1 is preferred after c0's last grant
        apply_stimulus(0, 1'b1, 1'b0, 8'h03, 32'h108, 32'h0, 4'hF);
        apply_stimulus(1, 1'b1, 1'b0, 8'h01, 32'h228, 32'h0, 4'hF);
        @(negedge clk);
        check_output("t4_c1_rdy", c1_if.req_rdy, 1'b1);
        check_output("t4_c0_rdy", c0_if.req_rdy, 1'b0);
        step();
        apply_stimulus(1, 1'b0, 1'b0, 8'h0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        check_output("t4_c0_rdy_next", c0_if.req_rdy, 1'b1);
        step();
        apply_stimulus(0, 1'b0, 1'b0, 8'h0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        check_output("t4_m_opq", m_if.req_opaque, 9'h003);
        apply_server_resp(1'b1, 1'b0, 9'h101, 32'h11111111);
        step();
        apply_server_resp(1'b1, 1'b0, 9'h003, 32'h33333333);
        @(negedge clk);
        check_output("t4_c1_resp_val", c1_if.resp_val, 1'b1);
        check_output("t4_c1_resp_opq", c1_if.resp_opaque, 8'h01);
        check_output("t4_c1_resp_data", c1_if.resp_data, 32'h11111111);
        check_output("t4_c0_resp_val0", c0_if.resp_val, 1'b0);
        step();
        apply_server_resp(1'b0, 1'b0, 9'h0, 32'h0);
        @(negedge clk);
        check_output("t4_c0_resp_val", c0_if.resp_val, 1'b1);
        check_output("t4_c0_resp_opq", c0_if.resp_opaque, 8'h03);
        check_output("t4_c0_resp_data", c0_if.resp_data, 32'h33333333);
        check_output("t4_c1_resp_val0", c1_if.resp_val, 1'b0);
        step();

        // Request back-pressure
        m_if.req_rdy = 1'b0;
        apply_stimulus(0, 1'b1, 1'b1, 8'h21, 32'h200, 32'hA5A5A5A5, 4'hF);
        @(negedge clk);
        check_output("t5_c0_rdy_first", c0_if.req_rdy, 1'b1);
        step();
        apply_stimulus(0, 1'b1, 1'b0, 8'h23, 32'h204, 32'h0, 4'hF);
        apply_stimulus(1, 1'b1, 1'b0, 8'h22, 32'h300, 32'h0, 4'hF);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_output($sformatf("t5_m_val_%0d", k), m_if.req_val, 1'b1);
            check_output($sformatf("t5_m_addr_%0d", k), m_if.req_addr, 32'h200);
            check_output($sformatf("t5_m_data_%0d", k), m_if.req_data, 32'hA5A5A5A5);
            check_output($sformatf("t5_m_opq_%0d", k), m_if.req_opaque, 9'h021);
            check_output($sformatf("t5_m_op_%0d", k), m_if.req_op, 1'b1);
            check_output($sformatf("t5_c0_rdy_%0d", k), c0_if.req_rdy, 1'b0);
            check_output($sformatf("t5_c1_rdy_%0d", k), c1_if.req_rdy, 1'b0);
            step();
        end
        m_if.req_rdy = 1'b1;
        @(negedge clk);
        check_output("t5_c1_rdy_go", c1_if.req_rdy, 1'b1);
        check_output("t5_c0_rdy_go", c0_if.req_rdy, 1'b0);
        step();
        apply_stimulus(1, 1'b0, 1'b0, 8'h0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        check_output("t5_m_opq_c1", m_if.req_opaque, 9'h122);
        check_output("t5_c0_rdy_turn", c0_if.req_rdy, 1'b1);
        step();
        apply_stimulus(0, 1'b0, 1'b0, 8'h0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        check_output("t5_m_opq_c0", m_if.req_opaque, 9'h023);
        step();

        // Response back-pressure; a write response reports zero data
        c0_if.resp_rdy = 1'b0;
        apply_server_resp(1'b1, 1'b1, 9'h021, 32'hFFFFFFFF);
        step();
        apply_server_resp(1'b1, 1'b0, 9'h122, 32'h12345678);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_output($sformatf("t6_c0_rval_%0d", k), c0_if.resp_val, 1'b1);
            check_output($sformatf("t6_c0_ropq_%0d", k), c0_if.resp_opaque, 8'h21);
            check_output($sformatf("t6_c0_rop_%0d", k), c0_if.resp_op, 1'b1);
            check_output($sformatf("t6_c0_rdata_%0d", k), c0_if.resp_data, 32'h0);
            check_output($sformatf("t6_m_resp_rdy_%0d", k), m_if.resp_rdy, 1'b0);
            check_output($sformatf("t6_c1_rval_%0d", k), c1_if.resp_val, 1'b0);
            step();
        end
        c0_if.resp_rdy = 1'b1;
        @(negedge clk);
        check_output("t6_m_resp_rdy_go", m_if.resp_rdy, 1'b1);
        step();
        apply_server_resp(1'b0, 1'b0, 9'h0, 32'h0);
        @(negedge clk);
        check_output("t6_c1_rval", c1_if.resp_val, 1'b1);
        check_output("t6_c1_rdata", c1_if.resp_data, 32'h12345678);
        check_output("t6_c0_rval_done", c0_if.resp_val, 1'b0);
        step();

        // Reset in the middle of traffic
        apply_stimulus(0, 1'b1, 1'b0, 8'h30, 32'h130, 32'h0, 4'hF);
        apply_stimulus(1, 1'b1, 1'b0, 8'h31, 32'h330, 32'h0, 4'hF);
        apply_server_resp(1'b1, 1'b0, 9'h023, 32'h77);
        step();
        #2;
        rst = 1'b0;
        #1;
        check_output("t7_m_req_val", m_if.req_val, 1'b0);
        check_output("t7_c0_resp_val", c0_if.resp_val, 1'b0);
        check_output("t7_c1_resp_val", c1_if.resp_val, 1'b0);
        check_output("t7_m_req_opaque", m_if.req_opaque, 9'h0);
        check_output("t7_m_req_addr", m_if.req_addr, 32'h0);
        apply_stimulus(0, 1'b0, 1'b0, 8'h0, 32'h0, 32'h0, 4'h0);
        apply_stimulus(1, 1'b0, 1'b0, 8'h0, 32'h0, 32'h0, 4'h0);
        apply_server_resp(1'b0, 1'b0, 9'h0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // After reset: c0 preferred, counters cleared, strict alternation
        apply_stimulus(0, 1'b1, 1'b0, 8'h40, 32'h400, 32'h0, 4'hF);
        apply_stimulus(1, 1'b1, 1'b0, 8'h41, 32'h500, 32'h0, 4'hF);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check_output($sformatf("t8_c0_rdy_%0d", k), c0_if.req_rdy, (k % 2) == 0);
            check_output($sformatf("t8_c1_rdy_%0d", k), c1_if.req_rdy, (k % 2) == 1);
            if (k > 0)
                check_output($sformatf("t8_m_opq_%0d", k), m_if.req_opaque,
                             ((k - 1) % 2 == 0) ? 9'h040 : 9'h141);
            echo_server();
            step();
        end
        apply_stimulus(0, 1'b0, 1'b0, 8'h0, 32'h0, 32'h0, 4'h0);
        apply_stimulus(1, 1'b0, 1'b0, 8'h0, 32'h0, 32'h0, 4'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            echo_server();
            step();
        end
        @(negedge clk);
        check_output("t8_m_req_idle", m_if.req_val, 1'b0);
        check_output("t8_c0_resp_idle", c0_if.resp_val, 1'b0);
        check_output("t8_c1_resp_idle", c1_if.resp_val, 1'b0);
`ifdef MEM_ARB_STATS_EN
        check_output("t8_stat_grant0", stat_grant0, 32'd10);
        check_output("t8_stat_grant1", stat_grant1, 32'd10);
        check_output("t8_stat_conflict", stat_conflict, 32'd20);
`endif

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_2to1.md
Name: mem_arbiter_2to1

Overview:
- Two-client to one-server memory arbiter directly downstream of the processor's inst_mem and data_mem client ports.
- Merges both streams onto the single backing memory port (simulation memory or FPGA BRAM wrapper).
- Tags each request with its source in an extra opaque MSB and routes responses back by that tag.
- Responses may return out of order; registered request and response paths give full throughput with bounded outstanding traffic.

Parameters:
- p_opaq_bits, 8, client-side opaque width; server side is p_opaq_bits+1.
- p_max_outstanding, 4, maximum in-flight requests per client (1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- cN_req_val/cN_req_rdy  in/out  1  client N request handshake; N in {0 = inst, 1 = data}.
- cN_req_op  in  1  0 = read, 1 = write.
- cN_req_opaque  in  p_opaq_bits  client tag.
- cN_req_addr  in  32  byte address.
- cN_req_data  in  32  write data.
- cN_req_strb  in  4  byte enables.
- cN_resp_val/cN_resp_rdy  out/in  1  client N response handshake.
- cN_resp_op  out  1  echoed op.
- cN_resp_opaque  out  p_opaq_bits  echoed tag.
- cN_resp_data  out  32  read data; 0 for writes.
- m_req_val/m_req_rdy  out/in  1  server request handshake.
- m_req_op, m_req_addr, m_req_data, m_req_strb  out  1/32/32/4  forwarded fields.
- m_req_opaque  out  p_opaq_bits+1  {src, client opaque}.
- m_resp_val/m_resp_rdy  in/out  1  server response handshake.
- m_resp_op, m_resp_opaque, m_resp_data  in  1/p_opaq_bits+1/32  server response.

Behaviour:
- Handshake: a transfer occurs when val&&rdy on a rising clk. val must not depend combinationally on rdy. Payload is held stable while val&&!rdy.
- Request register: one entry. It can accept when empty or draining this cycle (m_req_val&&m_req_rdy). Latency is 1 cycle from client handshake to m_req_val.
- Eligibility: client N is eligible when cN_req_val && out_cnt[N] < p_max_outstanding.
- Grant: cN_req_rdy = register can accept && client N granted. One grant per cycle.
- Round-robin: a priority bit selects the preferred client when both are eligible. After a grant the bit points to the other client. With no grant the bit holds.
- Outstanding counters: out_cnt[N] is $clog2(p_max_outstanding+1) bits.
  - Increments on client N request handshake.
  - Decrements on client N response handshake.
  - Both in one cycle: unchanged.
  - Never wraps: saturation at max blocks grant; a decrement at 0 is a bench error.
- Response register: one entry; m_resp_rdy = entry empty or draining. Routing uses m_resp_opaque MSB; the MSB is stripped on cN_resp_opaque. Only the addressed client sees resp_val; the other client's resp_val stays 0.
- Back-pressure: a stalled client response blocks the server response path for both clients. This is accepted; the processor always drains.
- Reset (rst=0, async): all val outputs 0, both registers empty, priority = client 0, counters 0, all data outputs 0. A reset mid-transaction drops in-flight requests and responses; the server is reset on the same rst.

Optional Feature:
- MEM_ARB_STATS_EN defined:
  - Adds outputs stat_grant0, stat_grant1 and stat_conflict (32 bits each).
  - Grant counters count request handshakes per client.
  - stat_conflict counts cycles where both clients were eligible.
  - All are wrap-around counters, cleared by rst.
- Undefined: the ports and counters are absent, with no other behavioural change.

Decomposition:
- Shared package mem_arb_pkg:
  - typedef mem_req_t {op, opaque, addr, data, strb}.
  - typedef mem_resp_t {op, opaque, data}.
  - MEM_OP_READ = 0, MEM_OP_WRITE = 1.
  - src id constants ARB_SRC_INST = 0, ARB_SRC_DATA = 1.
- Sub-module pipe_reg_1entry (parameterised payload type, val/rdy in and out) is instantiated twice: request path and response path.
- Arbitration, counters and routing stay in the top module.

Test Plan:
- Single read from c0 (addr 0x100, opaque 0x05):
  - m_req_val rises 1 cycle later with opaque 0x005.
  - Server returns data 0xDEADBEEF → c0_resp_data 0xDEADBEEF, opaque 0x05; c1_resp_val stays 0.
- Both clients request every cycle with m_req_rdy=1: grants alternate 0,1,0,1; m_req_opaque MSB toggles each cycle; neither client starves.
- c1 issues 4 reads with no responses (p_max_outstanding=4): 5th request sees c1_req_rdy=0, c0 still granted; one c1 response re-enables c1 next cycle.
- Out-of-order return: server responds opaque 0x101 before 0x003 → c1 receives 0x01 first, then c0 receives 0x03.
- Back-pressure: m_req_rdy=0 for 3 cycles → m_req payload stable, both cN_req_rdy=0; c0_resp_rdy=0 holds c0 response and m_resp_rdy=0.
- Assert rst low mid-burst: all val outputs 0 immediately, counters 0, priority = client 0. With MEM_ARB_STATS_EN, 10 grants each give stat_grant0 = 10 and stat_grant1 = 10.
